// File: rtl/shift_deserializer.sv
// LSB-first serial-to-parallel collector with a registered valid/ready word output
// and a sticky overrun flag for words dropped under backpressure.
module shift_deserializer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       din,
   input  logic                       flush,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   output logic                       overrun,
   output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] word_c;
   logic             capture_c;
   logic             last_c;
   logic             complete_c;
   logic             accept_c;

   logic [WIDTH-1:0] sh_nxt;
   logic [CW-1:0]    bit_cnt_nxt;
   logic [WIDTH-1:0] out_data_nxt;
   logic             out_valid_nxt;
   logic             overrun_nxt;

   assign word_c     = {din, sh[WIDTH-1:1]};
   assign capture_c  = enable & ~flush;
   assign last_c     = (bit_cnt == CW'(WIDTH - 1));
   assign complete_c = capture_c & last_c;
   // A completed word is taken if the output slot is empty or drains on this edge.
   assign accept_c   = ~out_valid | out_ready;

   // Next-state for the shifter, counter and output handshake.
   always_comb begin
      sh_nxt        = sh;
      bit_cnt_nxt   = bit_cnt;
      out_data_nxt  = out_data;
      out_valid_nxt = out_valid;
      overrun_nxt   = overrun;

      if (flush) begin
         sh_nxt      = '0;
         bit_cnt_nxt = '0;
         overrun_nxt = 1'b0;
      end else if (enable) begin
         sh_nxt      = word_c;
         bit_cnt_nxt = last_c ? '0 : bit_cnt + CW'(1);
      end

      if (complete_c) begin
         if (accept_c) begin
            out_data_nxt  = word_c;
            out_valid_nxt = 1'b1;
         end else begin
            overrun_nxt = 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid_nxt = 1'b0;
      end
   end

   // State registers; reset is asynchronous and active-low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh        <= '0;
         bit_cnt   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         sh        <= sh_nxt;
         bit_cnt   <= bit_cnt_nxt;
         out_data  <= out_data_nxt;
         out_valid <= out_valid_nxt;
         overrun   <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: table-driven streams plus hand-written corner
// sequences, with a scoreboard queue checked on every output transfer.
module tb_shift_deserializer;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             enable;
   logic             din;
   logic             flush;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             overrun;
   logic [1:0]       bit_cnt;

   int tests;
   int fails;
   logic [WIDTH-1:0] sb[$];

   typedef struct {
      logic [7:0] bits;   // bit i is sent i-th
      int         nbits;
      logic [3:0] exp0;
      logic [3:0] exp1;
   } vec_t;

   vec_t vecs[5];

   shift_deserializer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .din       (din),
      .flush     (flush),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .overrun   (overrun),
      .bit_cnt   (bit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at posedge+1; drives one bit, returns at the next posedge+1.
   task automatic send_bit(input logic b);
      enable = 1'b1;
      din    = b;
      @(posedge clk);
      #1;
      enable = 1'b0;
      din    = 1'b0;
   endtask

   task automatic idle(input int n);
      enable = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // A transfer happens at the next posedge whenever valid and ready are both high here.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got %0h expected none at %0t", out_data, $time);
         end else begin
            check("sb_word", 32'(out_data), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      vecs[0] = '{bits: 8'h0D, nbits: 4, exp0: 4'hD, exp1: 4'h0};
      vecs[1] = '{bits: 8'h7A, nbits: 8, exp0: 4'hA, exp1: 4'h7};
      vecs[2] = '{bits: 8'h00, nbits: 4, exp0: 4'h0, exp1: 4'h0};
      vecs[3] = '{bits: 8'h1F, nbits: 8, exp0: 4'hF, exp1: 4'h1};
      vecs[4] = '{bits: 8'h96, nbits: 8, exp0: 4'h6, exp1: 4'h9};

      rst = 1'b0; enable = 1'b0; din = 1'b0; flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_data", 32'(out_data), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      check("rst_bitcnt", 32'(bit_cnt), 32'h0);
      rst = 1'b1;
      idle(1);

      // Table-driven streams with the consumer always ready.
      out_ready = 1'b1;
      foreach (vecs[v]) begin
         for (int i = 0; i < vecs[v].nbits; i++) begin
            logic [7:0] bits;
            bits = vecs[v].bits;
            if ((i % 4) == 3) sb.push_back((i < 4) ? vecs[v].exp0 : vecs[v].exp1);
            send_bit(bits[i]);
            if ((i % 4) == 3) begin
               check("vec_data", 32'(out_data), 32'((i < 4) ? vecs[v].exp0 : vecs[v].exp1));
               check("vec_valid", 32'(out_valid), 32'h1);
               check("vec_bitcnt", 32'(bit_cnt), 32'h0);
               check("vec_overrun", 32'(overrun), 32'h0);
            end
         end
         idle(2);
         check("vec_drained", 32'(out_valid), 32'h0);
      end

      // Backpressure: 4'h3 held, 4'hC dropped, overrun sticky until flush.
      out_ready = 1'b0;
      sb.push_back(4'h3);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      check("ovr_data", 32'(out_data), 32'h3);
      check("ovr_valid", 32'(out_valid), 32'h1);
      check("ovr_flag", 32'(overrun), 32'h1);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      check("ovr_drained", 32'(out_valid), 32'h0);
      check("ovr_sticky", 32'(overrun), 32'h1);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      check("ovr_flushed", 32'(overrun), 32'h0);

      // Gaps between bits: counter holds.
      out_ready = 1'b1;
      send_bit(1'b1); send_bit(1'b1);
      for (int g = 0; g < 5; g++) begin
         idle(1);
         check("gap_bitcnt", 32'(bit_cnt), 32'h2);
      end
      sb.push_back(4'h3);
      send_bit(1'b0); send_bit(1'b0);
      check("gap_data", 32'(out_data), 32'h3);
      idle(2);

      // Flush mid-word with a pending word; din on the flush edge is ignored.
      out_ready = 1'b0;
      sb.push_back(4'h5);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1);
      check("fl_pre_bitcnt", 32'(bit_cnt), 32'h2);
      flush = 1'b1;
      send_bit(1'b1);
      flush = 1'b0;
      check("fl_bitcnt", 32'(bit_cnt), 32'h0);
      check("fl_valid", 32'(out_valid), 32'h1);
      check("fl_data", 32'(out_data), 32'h5);
      out_ready = 1'b1;
      idle(1);
      sb.push_back(4'h9);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
      check("fl_word", 32'(out_data), 32'h9);
      check("fl_overrun", 32'(overrun), 32'h0);
      idle(2);

      // Back-to-back: completion coincides with consumption, no bubble.
      out_ready = 1'b0;
      sb.push_back(4'hA);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      out_ready = 1'b1;
      sb.push_back(4'h7);
      send_bit(1'b0);
      check("b2b_valid", 32'(out_valid), 32'h1);
      check("b2b_data", 32'(out_data), 32'h7);
      check("b2b_overrun", 32'(overrun), 32'h0);
      idle(2);

      // Asynchronous reset mid-word with a pending word.
      out_ready = 1'b0;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      check("ar_pending", 32'(out_data), 32'hD);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      check("ar_pre_bitcnt", 32'(bit_cnt), 32'h3);
      #2;
      rst = 1'b0;
      #1;
      check("ar_data", 32'(out_data), 32'h0);
      check("ar_valid", 32'(out_valid), 32'h0);
      check("ar_overrun", 32'(overrun), 32'h0);
      check("ar_bitcnt", 32'(bit_cnt), 32'h0);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      sb.push_back(4'h6);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      check("ar_fresh", 32'(out_data), 32'h6);
      idle(3);

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel collector that sits directly downstream of the right-shifting serial divider stage. It samples one bit per enabled clock, LSB first, and assembles WIDTH-bit words. Completed words go to a registered output with a valid/ready handshake. A sticky overrun flag records words lost to backpressure.

## Interface
Parameters:
- WIDTH, 4, word length in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- enable  input  1  serial bit valid; din is sampled on a rising clk edge when enable=1.
- din  input  1  serial data bit, LSB of the word first.
- flush  input  1  synchronous clear of the partial word and the overrun flag; has priority over enable.
- out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1 on the same edge.
- out_data  output  WIDTH  assembled word, held stable while out_valid=1.
- out_valid  output  1  out_data holds an unconsumed word.
- overrun  output  1  sticky flag; a completed word was dropped.
- bit_cnt  output  clog2(WIDTH)  number of bits collected in the current partial word.

## Operation
- Internal state: shift register sh[WIDTH-1:0], bit_cnt, out_data, out_valid, overrun.
- Reset (rst=0): sh=0, bit_cnt=0, out_data=0, out_valid=0, overrun=0.
- Bit capture on enable=1 with flush=0: sh <= {din, sh[WIDTH-1:1]}, so the first bit lands in bit 0 after WIDTH shifts.
- Counter: bit_cnt increments on each captured bit. When bit_cnt==WIDTH-1 and a bit is captured, the word completes and bit_cnt wraps to 0.
- Completion: the completed word is {din, sh[WIDTH-1:1]}.
  - If out_valid=0, or out_valid=1 and out_ready=1 on the same edge, load out_data with the word and set out_valid=1.
  - Otherwise the word is discarded, out_data and out_valid keep their values, and overrun is set to 1.
- Consumption: out_valid=1 and out_ready=1 with no completion on that edge clears out_valid. out_data keeps its last value.
- Flush (flush=1): sh=0, bit_cnt=0, overrun=0, and din is ignored on that edge. out_data, out_valid and the handshake are unaffected, so a pending word survives a flush.
- enable=0: sh and bit_cnt hold. Gaps between bits of any length are legal.
- overrun clears only on reset or flush.

## Timing
- Latency: out_valid rises on the same rising edge that samples the WIDTH-th bit, so out_data is visible in the following cycle.
- Sustained rate: one word per WIDTH enabled cycles with no loss, provided out_ready=1 at every completion edge where out_valid=1.
- Back-to-back: a completion edge with out_valid=1 and out_ready=1 replaces the word. out_valid stays 1 with no bubble.
- Reset mid-word: the partial word is lost. After rst deasserts, the next enabled bit is bit 0.
- Reset mid-handshake: out_valid drops immediately (asynchronous), regardless of out_ready.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- WIDTH=4, out_ready=1, enable=1 for 4 cycles with din=1,0,1,1 -> after the 4th edge out_data=4'hD, out_valid=1, bit_cnt=0, overrun=0.
- Continuous stream of 8 bits 0,1,0,1,1,1,1,0 with out_ready=1 -> 4'hA, then 4'h7 on consecutive completions; out_valid stays high with no gap.
- out_ready=0, stream 4'h3 then 4'hC -> out_data stays 4'h3, overrun=1 after the 8th bit. Raising out_ready then gives one transfer of 4'h3 and out_valid=0.
- Two bits 1,1, then enable=0 for 5 cycles, then bits 0,0 -> out_data=4'h3; bit_cnt holds at 2 during the gap.
- Two bits captured, flush=1 for one cycle, then bits 1,0,0,1 -> out_data=4'h9, bit_cnt=0 after flush. A pending out_valid=1 is preserved across the flush.
- Assert rst=0 asynchronously mid-word (bit_cnt=3, out_valid=1) -> all outputs 0 without waiting for a clk edge. The next 4 bits form a fresh word.
